// File: rtl/conv_layer_output_interface.sv
// conv_layer_output_interface
//
// Write-back buffer between the conv kernel array and external result RAM.
// A CAPTURE command latches one parallel word of ARRAY_SIZE results; a STORE
// command then streams those results to RAM, one per cycle, starting with
// element 0 (the MS slice of data_in), at an auto-incrementing address.
// After FRAME_SIZE results the address and count wrap to 0 and FRAME_FIN is
// reported instead of STORE_FIN.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   enable       in   global advance; low freezes state and suppresses we/ack
//   cmd          in   0 NONE, 1 CAPTURE, 2 STORE, 3 CLEAR
//   data_in      in   ARRAY_SIZE*DATA_WIDTH kernel results, element 0 in MS slice
//   data_valid   in   data_in valid this cycle
//   ack          out  0 IDLE, 1 CAPTURE_FIN, 2 STORE_FIN, 3 FRAME_FIN (1-cycle pulse)
//   ext_ram_addr out  write address (registered)
//   ext_ram_data out  write data (registered)
//   ext_ram_we   out  write strobe (registered)
//
// Build option:
//   CONV_OUT_RELU_EN  when defined, results with the sign bit set (negative
//                     values and -0.0) are written as 0; the buffer is untouched.
//
// States:
//   state   | meaning
//   INIT    | nothing captured yet; only CAPTURE is accepted
//   IDLE    | buffer holds a word; waits for CAPTURE / STORE / CLEAR
//   CAPTURE | waiting for data_valid to latch data_in
//   STORE   | streaming buffer elements to RAM, one per cycle

module conv_layer_output_interface #(
  parameter int ARRAY_SIZE     = 6,
  parameter int DATA_WIDTH     = 32,
  parameter int EXT_ADDR_WIDTH = 10,
  parameter int FRAME_SIZE     = 36
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic [1:0]                       cmd,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] data_in,
  input  logic                             data_valid,
  output logic [1:0]                       ack,
  output logic [EXT_ADDR_WIDTH-1:0]        ext_ram_addr,
  output logic [DATA_WIDTH-1:0]            ext_ram_data,
  output logic                             ext_ram_we
);

  localparam int IDX_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam int CNT_W = $clog2(FRAME_SIZE + 1);

  localparam logic [1:0] CMD_CAPTURE = 2'd1;
  localparam logic [1:0] CMD_STORE   = 2'd2;
  localparam logic [1:0] CMD_CLEAR   = 2'd3;

  localparam logic [1:0] ACK_IDLE        = 2'd0;
  localparam logic [1:0] ACK_CAPTURE_FIN = 2'd1;
  localparam logic [1:0] ACK_STORE_FIN   = 2'd2;
  localparam logic [1:0] ACK_FRAME_FIN   = 2'd3;

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_IDLE    = 2'd1,
    S_CAPTURE = 2'd2,
    S_STORE   = 2'd3
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [DATA_WIDTH-1:0]     data_buf [ARRAY_SIZE];
  logic [IDX_W-1:0]          idx;
  logic [EXT_ADDR_WIDTH-1:0] wr_ptr;
  logic [CNT_W-1:0]          wr_cnt;

  logic                      last_elem;
  logic                      frame_end;
  logic [DATA_WIDTH-1:0]     cur_elem;
  logic [DATA_WIDTH-1:0]     wr_data;

  logic [1:0]                ack_nxt;
  logic                      we_nxt;
  logic [EXT_ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0]     data_nxt;

  assign last_elem = (idx == IDX_W'(ARRAY_SIZE - 1));
  // FRAME_SIZE is a multiple of ARRAY_SIZE, so the frame can only end on the
  // last element of a word; qualifying with last_elem keeps that explicit.
  assign frame_end = last_elem && ((wr_cnt + CNT_W'(1)) == CNT_W'(FRAME_SIZE));
  assign cur_elem  = data_buf[idx];

`ifdef CONV_OUT_RELU_EN
  assign wr_data = cur_elem[DATA_WIDTH-1] ? '0 : cur_elem;
`else
  assign wr_data = cur_elem;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (enable) begin
      case (state)
        S_INIT: begin
          if (cmd == CMD_CAPTURE) state_nxt = S_CAPTURE;
        end
        S_IDLE: begin
          case (cmd)
            CMD_CAPTURE: state_nxt = S_CAPTURE;
            CMD_STORE:   state_nxt = S_STORE;
            CMD_CLEAR:   state_nxt = S_INIT;
            default:     state_nxt = S_IDLE;
          endcase
        end
        S_CAPTURE: begin
          if (data_valid) state_nxt = S_IDLE;
        end
        S_STORE: begin
          if (last_elem) state_nxt = S_IDLE;
        end
        default: state_nxt = S_INIT;
      endcase
    end
  end

  // Output logic: next values of the registered RAM port and ack.
  // Address and data hold between writes; we and ack are pulses.
  always_comb begin
    ack_nxt  = ACK_IDLE;
    we_nxt   = 1'b0;
    addr_nxt = ext_ram_addr;
    data_nxt = ext_ram_data;
    if (enable) begin
      case (state)
        S_CAPTURE: begin
          if (data_valid) ack_nxt = ACK_CAPTURE_FIN;
        end
        S_STORE: begin
          we_nxt   = 1'b1;
          addr_nxt = wr_ptr;
          data_nxt = wr_data;
          if (last_elem) ack_nxt = frame_end ? ACK_FRAME_FIN : ACK_STORE_FIN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack          <= ACK_IDLE;
      ext_ram_we   <= 1'b0;
      ext_ram_addr <= '0;
      ext_ram_data <= '0;
    end else begin
      ack          <= ack_nxt;
      ext_ram_we   <= we_nxt;
      ext_ram_addr <= addr_nxt;
      ext_ram_data <= data_nxt;
    end
  end

  // Buffer, element index and write pointer/count
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      wr_ptr <= '0;
      wr_cnt <= '0;
      for (int i = 0; i < ARRAY_SIZE; i++) data_buf[i] <= '0;
    end else if (enable) begin
      case (state)
        S_IDLE: begin
          if (cmd == CMD_CLEAR) begin
            idx    <= '0;
            wr_ptr <= '0;
            wr_cnt <= '0;
            for (int i = 0; i < ARRAY_SIZE; i++) data_buf[i] <= '0;
          end
        end
        S_CAPTURE: begin
          if (data_valid) begin
            for (int i = 0; i < ARRAY_SIZE; i++)
              data_buf[i] <= data_in[(ARRAY_SIZE-1-i)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        S_STORE: begin
          idx <= last_elem ? '0 : idx + IDX_W'(1);
          if (frame_end) begin
            wr_ptr <= '0;
            wr_cnt <= '0;
          end else begin
            wr_ptr <= wr_ptr + EXT_ADDR_WIDTH'(1);
            wr_cnt <= wr_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_output_interface.sv
module tb_conv_layer_output_interface;

  localparam int AS = 6;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int FS = 36;

  localparam logic [1:0] CMD_NONE    = 2'd0;
  localparam logic [1:0] CMD_CAPTURE = 2'd1;
  localparam logic [1:0] CMD_STORE   = 2'd2;
  localparam logic [1:0] CMD_CLEAR   = 2'd3;
  localparam logic [1:0] ACK_CAP     = 2'd1;
  localparam logic [1:0] ACK_STORE   = 2'd2;
  localparam logic [1:0] ACK_FRAME   = 2'd3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b1;
  logic [1:0]        cmd = CMD_NONE;
  logic [AS*DW-1:0]  data_in = '0;
  logic              data_valid = 1'b0;
  logic [1:0]        ack;
  logic [AW-1:0]     ext_ram_addr;
  logic [DW-1:0]     ext_ram_data;
  logic              ext_ram_we;

  conv_layer_output_interface #(
    .ARRAY_SIZE(AS), .DATA_WIDTH(DW), .EXT_ADDR_WIDTH(AW), .FRAME_SIZE(FS)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cmd(cmd), .data_in(data_in),
    .data_valid(data_valid), .ack(ack), .ext_ram_addr(ext_ram_addr),
    .ext_ram_data(ext_ram_data), .ext_ram_we(ext_ram_we)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           wq[$];
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] stim  [AS];
  logic [DW-1:0] m_buf [AS];
  logic [AW-1:0] m_ptr = '0;
  int            m_cnt = 0;

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef CONV_OUT_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Scoreboard: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (ext_ram_we === 1'b1) begin
      wr_t e;
      total++;
      if (wq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%0d data=%h (no write expected)", ext_ram_addr, ext_ram_data);
      end else begin
        e = wq.pop_front();
        if (ext_ram_addr !== e.addr || ext_ram_data !== e.data) begin
          bad++;
          $display("FAIL write addr=%0d data=%h expected addr=%0d data=%h",
                   ext_ram_addr, ext_ram_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_clear();
    m_ptr = '0;
    m_cnt = 0;
    for (int i = 0; i < AS; i++) m_buf[i] = '0;
  endtask

  task automatic push_writes();
    for (int i = 0; i < AS; i++) begin
      wr_t e;
      e.addr = m_ptr;
      e.data = relu(m_buf[i]);
      wq.push_back(e);
      m_ptr = m_ptr + 1'b1;
      m_cnt++;
      if (m_cnt == FS) begin
        m_ptr = '0;
        m_cnt = 0;
      end
    end
  endtask

  task automatic do_clear();
    tick(); cmd = CMD_CLEAR;
    tick(); cmd = CMD_NONE;
    model_clear();
  endtask

  task automatic do_capture();
    tick(); cmd = CMD_CAPTURE;
    tick(); cmd = CMD_NONE;
    for (int i = 0; i < AS; i++) data_in[(AS-1-i)*DW +: DW] = stim[i];
    data_valid = 1'b1;
    @(negedge clk);
    total++;
    if (ack !== 2'd0) begin
      bad++;
      $display("FAIL capture_early_ack ack=%0d expected 0", ack);
    end
    tick();
    data_valid = 1'b0;
    data_in = {AS{32'hDEAD_BEEF}};
    @(negedge clk);
    total++;
    if (ack !== ACK_CAP) begin
      bad++;
      $display("FAIL capture_ack ack=%0d expected %0d", ack, ACK_CAP);
    end
    for (int i = 0; i < AS; i++) m_buf[i] = stim[i];
  endtask

  // Issues STORE and tracks writes/ack; optional 3-cycle enable stall after
  // stall_at writes.
  task automatic run_store(input logic [1:0] exp_ack, input int stall_at, input string nm);
    int cyc, writes, ack_cyc, exp_cyc;
    logic [1:0] ack_v;
    logic ack_we;
    bit stalled;
    push_writes();
    tick(); cmd = CMD_STORE;
    tick(); cmd = CMD_NONE;
    cyc = 0; writes = 0; ack_cyc = -1; ack_v = 2'd0; ack_we = 1'b0; stalled = 0;
    while (ack_cyc < 0 && cyc < AS + 12) begin
      @(negedge clk);
      cyc++;
      if (ext_ram_we === 1'b1) writes++;
      if (ack !== 2'd0) begin
        ack_cyc = cyc; ack_v = ack; ack_we = ext_ram_we;
      end
      if (stall_at > 0 && !stalled && writes == stall_at) begin
        stalled = 1;
        enable = 1'b0;
        repeat (3) begin
          @(negedge clk);
          cyc++;
          total++;
          if (ext_ram_we !== 1'b0 || ack !== 2'd0) begin
            bad++;
            $display("FAIL %s stall we=%b ack=%0d expected we=0 ack=0", nm, ext_ram_we, ack);
          end
        end
        enable = 1'b1;
      end
    end
    exp_cyc = AS + 1 + ((stall_at > 0) ? 3 : 0);
    total++;
    if (ack_v !== exp_ack) begin
      bad++;
      $display("FAIL %s ack=%0d expected %0d", nm, ack_v, exp_ack);
    end
    total++;
    if (ack_cyc !== exp_cyc) begin
      bad++;
      $display("FAIL %s ack_latency=%0d expected %0d", nm, ack_cyc, exp_cyc);
    end
    total++;
    if (ack_we !== 1'b1 || writes !== AS) begin
      bad++;
      $display("FAIL %s ack_with_last_write we=%b writes=%0d expected we=1 writes=%0d", nm, ack_we, writes, AS);
    end
    @(negedge clk);
    total++;
    if (ext_ram_we !== 1'b0 || ack !== 2'd0 || wq.size() !== 0) begin
      bad++;
      $display("FAIL %s after_store we=%b ack=%0d pending=%0d expected 0 0 0", nm, ext_ram_we, ack, wq.size());
    end
    wq.delete();
  endtask

  task automatic check_no_write(input int cycles, input string nm);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (ext_ram_we !== 1'b0 || ack !== 2'd0) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL %s activity_cycles=%0d expected 0", nm, seen);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (ack !== 2'd0 || ext_ram_addr !== '0 || ext_ram_data !== '0 || ext_ram_we !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs ack=%0d addr=%0d data=%h we=%b expected all 0",
               ack, ext_ram_addr, ext_ram_data, ext_ram_we);
    end
    rst = 1'b0;
    tick(); cmd = CMD_STORE;
    tick(); cmd = CMD_NONE;
    check_no_write(8, "store_in_init_after_reset");
  endtask

  task automatic test_single_writeback();
    stim[0] = 32'h3F80_0000; stim[1] = 32'h4000_0000; stim[2] = 32'h4040_0000;
    stim[3] = 32'h4080_0000; stim[4] = 32'h40A0_0000; stim[5] = 32'h40C0_0000;
    do_capture();
    // data_valid outside CAPTURE must not touch the buffer
    tick(); data_valid = 1'b1; data_in = {AS{32'h1234_5678}};
    tick(); data_valid = 1'b0;
    run_store(ACK_STORE, 0, "single");
    total++;
    if (ext_ram_addr !== 10'd5 || ext_ram_data !== 32'h40C0_0000) begin
      bad++;
      $display("FAIL single_last addr=%0d data=%h expected 5 40c00000", ext_ram_addr, ext_ram_data);
    end
  endtask

  task automatic test_stall();
    do_clear();
    for (int i = 0; i < AS; i++) stim[i] = 32'h4100_0000 + i;
    do_capture();
    run_store(ACK_STORE, 3, "stall");
  endtask

  task automatic test_frame();
    do_clear();
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < AS; i++) stim[i] = 32'h4200_0000 + (k << 8) + i;
      do_capture();
      run_store((k == 5) ? ACK_FRAME : ACK_STORE, 0, $sformatf("frame_store%0d", k));
      if (k == 5) begin
        total++;
        if (ext_ram_addr !== 10'd35) begin
          bad++;
          $display("FAIL frame_last_addr addr=%0d expected 35", ext_ram_addr);
        end
      end
    end
    total++;
    if (ext_ram_addr !== 10'd5) begin
      bad++;
      $display("FAIL frame_wrap_addr addr=%0d expected 5", ext_ram_addr);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < AS; i++) stim[i] = 32'h4300_0000 + i;
    do_capture();
    run_store(ACK_STORE, 0, "clear_pre1");
    run_store(ACK_STORE, 0, "clear_pre2");
    do_clear();
    tick(); cmd = CMD_STORE;
    tick(); cmd = CMD_NONE;
    check_no_write(8, "store_in_init_after_clear");
    for (int i = 0; i < AS; i++) stim[i] = 32'h4400_0000 + i;
    do_capture();
    run_store(ACK_STORE, 0, "clear_post");
    total++;
    if (ext_ram_addr !== 10'd5) begin
      bad++;
      $display("FAIL clear_restart addr=%0d expected 5", ext_ram_addr);
    end
  endtask

  task automatic test_relu();
    stim[0] = 32'hBF80_0000; stim[1] = 32'h8000_0000; stim[2] = 32'h3F80_0000;
    stim[3] = 32'h7F7F_FFFF; stim[4] = 32'hC000_0000; stim[5] = 32'h0000_0001;
    do_capture();
    run_store(ACK_STORE, 0, "relu");
  endtask

  task automatic test_reset_mid_store();
    int writes, cyc;
    for (int i = 0; i < AS; i++) stim[i] = 32'h4500_0000 + i;
    do_capture();
    push_writes();
    tick(); cmd = CMD_STORE;
    tick(); cmd = CMD_NONE;
    writes = 0; cyc = 0;
    while (writes < 3 && cyc < AS + 6) begin
      @(negedge clk);
      cyc++;
      if (ext_ram_we === 1'b1) writes++;
    end
    total++;
    if (writes !== 3) begin
      bad++;
      $display("FAIL reset_mid_reach writes=%0d expected 3", writes);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (ack !== 2'd0 || ext_ram_addr !== '0 || ext_ram_data !== '0 || ext_ram_we !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_outputs ack=%0d addr=%0d data=%h we=%b expected all 0",
               ack, ext_ram_addr, ext_ram_data, ext_ram_we);
    end
    rst = 1'b0;
    wq.delete();
    model_clear();
    tick(); cmd = CMD_STORE;
    tick(); cmd = CMD_NONE;
    check_no_write(10, "store_after_mid_reset");
  endtask

  initial begin
    for (int i = 0; i < AS; i++) begin
      stim[i] = '0;
      m_buf[i] = '0;
    end
    test_reset();
    test_single_writeback();
    test_stall();
    test_frame();
    test_clear();
    test_relu();
    test_reset_mid_store();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
